// File: rtl/slb_if.sv
// Store/load buffer bus: dispatch, CDB snoop, ROB commit,
// memory port and result port grouped in one interface.
`ifndef SLB_OPS
`define SLB_OPS
`define LB  3'd0
`define LH  3'd1
`define LW  3'd2
`define LBU 3'd3
`define LHU 3'd4
`define SB  3'd5
`define SH  3'd6
`define SW  3'd7
`endif

interface slb_if;
    logic        rdy;
    logic        iclr;
    logic        iDP_en;
    logic [2:0]  iDP_op;
    logic [31:0] iDP_imm;
    logic [4:0]  iDP_rd_nick;
    logic [31:0] iDP_rs1_dt;
    logic [4:0]  iDP_rs1_nick;
    logic [31:0] iDP_rs2_dt;
    logic [4:0]  iDP_rs2_nick;
    logic        oDP_full;
    logic        iEX_en;
    logic [4:0]  iEX_nick;
    logic [31:0] iEX_dt;
    logic        iROB_store_en;
    logic [4:0]  iROB_store_nick;
    logic        oMEM_en;
    logic        oMEM_wr;
    logic [31:0] oMEM_addr;
    logic [31:0] oMEM_dt;
    logic [1:0]  oMEM_len;
    logic        iMEM_done;
    logic [31:0] iMEM_dt;
    logic        oROB_en;
    logic [4:0]  oROB_nick;
    logic [31:0] oROB_dt;

    modport master (
        output rdy, iclr, iDP_en, iDP_op, iDP_imm, iDP_rd_nick,
        output iDP_rs1_dt, iDP_rs1_nick, iDP_rs2_dt, iDP_rs2_nick,
        output iEX_en, iEX_nick, iEX_dt,
        output iROB_store_en, iROB_store_nick,
        output iMEM_done, iMEM_dt,
        input  oDP_full, oMEM_en, oMEM_wr, oMEM_addr, oMEM_dt, oMEM_len,
        input  oROB_en, oROB_nick, oROB_dt
    );

    modport slave (
        input  rdy, iclr, iDP_en, iDP_op, iDP_imm, iDP_rd_nick,
        input  iDP_rs1_dt, iDP_rs1_nick, iDP_rs2_dt, iDP_rs2_nick,
        input  iEX_en, iEX_nick, iEX_dt,
        input  iROB_store_en, iROB_store_nick,
        input  iMEM_done, iMEM_dt,
        output oDP_full, oMEM_en, oMEM_wr, oMEM_addr, oMEM_dt, oMEM_len,
        output oROB_en, oROB_nick, oROB_dt
    );
endinterface

// File: rtl/slb.sv
// Store/load buffer: 16-entry in-order queue of memory ops,
// operand snooping, commit-gated stores, one access at a time.
module slb (
    input  logic clk,
    input  logic rst,
    slb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

    state_t      state, state_nx;
    logic [15:0] vld, com;
    logic [2:0]  e_op  [16];
    logic [31:0] e_imm [16];
    logic [4:0]  e_rd  [16];
    logic [31:0] e_s1  [16];
    logic [4:0]  e_n1  [16];
    logic [31:0] e_s2  [16];
    logic [4:0]  e_n2  [16];
    logic [3:0]  head, tail;
    logic [4:0]  count;
    logic        full, push, pop, h_st, ld_go, st_go, issue;

    function automatic logic is_st(input logic [2:0] op);
        return op == `SB || op == `SH || op == `SW;
    endfunction

    function automatic logic [1:0] len_of(input logic [2:0] op);
        unique case (op)
            `LB, `LBU, `SB: return 2'b00;
            `LH, `LHU, `SH: return 2'b01;
            default:        return 2'b11;
        endcase
    endfunction

    function automatic logic [31:0] ld_fmt(input logic [2:0] op,
                                           input logic [31:0] d);
        unique case (op)
            `LB:     return {{24{d[7]}}, d[7:0]};
            `LH:     return {{16{d[15]}}, d[15:0]};
            `LBU:    return {24'd0, d[7:0]};
            `LHU:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // A waiting operand matches either the CDB or our own result port.
    function automatic logic hit(input logic [4:0] n);
        return n != 5'd0 &&
               ((bus.iEX_en && n == bus.iEX_nick) ||
                (bus.oROB_en && n == bus.oROB_nick));
    endfunction

    function automatic logic [31:0] hit_dt(input logic [4:0] n);
        return (bus.iEX_en && n == bus.iEX_nick) ? bus.iEX_dt : bus.oROB_dt;
    endfunction

    assign full         = (count == 5'd16);
    assign bus.oDP_full = full;
    assign push         = bus.iDP_en && !full;
    assign h_st         = is_st(e_op[head]);
    assign ld_go        = vld[head] && !h_st && e_n1[head] == 5'd0;
    assign st_go        = vld[head] && h_st && com[head] &&
                          e_n1[head] == 5'd0 && e_n2[head] == 5'd0;
    assign pop          = state != IDLE && bus.iMEM_done;
    assign issue        = state == IDLE && (ld_go || st_go);

    // Head FSM state register, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst)          state <= IDLE;
        else if (bus.rdy) state <= state_nx;
    end

    // Next head state: issue from IDLE, return on completion or flush.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ld_go)      state_nx = LOAD_WAIT;
                else if (st_go) state_nx = STORE_WAIT;
            end
            LOAD_WAIT, STORE_WAIT: begin
                if (bus.iMEM_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.iclr) state_nx = IDLE;
    end

    // Queue storage: snoop, commit marking, pop at head, push at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0; com <= '0;
            head <= '0; tail <= '0; count <= '0;
        end else if (bus.rdy) begin
            if (bus.iclr) begin
                vld <= '0; com <= '0;
                head <= '0; tail <= '0; count <= '0;
            end else begin
                for (int i = 0; i < 16; i++) begin
                    if (vld[i] && hit(e_n1[i])) begin
                        e_s1[i] <= hit_dt(e_n1[i]);
                        e_n1[i] <= 5'd0;
                    end
                    if (vld[i] && hit(e_n2[i])) begin
                        e_s2[i] <= hit_dt(e_n2[i]);
                        e_n2[i] <= 5'd0;
                    end
                    if (vld[i] && is_st(e_op[i]) && bus.iROB_store_en &&
                        e_rd[i] == bus.iROB_store_nick)
                        com[i] <= 1'b1;
                end
                if (pop) begin
                    vld[head] <= 1'b0;
                    com[head] <= 1'b0;
                    head      <= head + 4'd1;
                end
                if (push) begin
                    e_op[tail]  <= bus.iDP_op;
                    e_imm[tail] <= bus.iDP_imm;
                    e_rd[tail]  <= bus.iDP_rd_nick;
                    e_s1[tail]  <= hit(bus.iDP_rs1_nick) ?
                                   hit_dt(bus.iDP_rs1_nick) : bus.iDP_rs1_dt;
                    e_n1[tail]  <= hit(bus.iDP_rs1_nick) ?
                                   5'd0 : bus.iDP_rs1_nick;
                    e_s2[tail]  <= hit(bus.iDP_rs2_nick) ?
                                   hit_dt(bus.iDP_rs2_nick) : bus.iDP_rs2_dt;
                    e_n2[tail]  <= hit(bus.iDP_rs2_nick) ?
                                   5'd0 : bus.iDP_rs2_nick;
                    vld[tail]   <= 1'b1;
                    com[tail]   <= 1'b0;
                    tail        <= tail + 4'd1;
                end
                count <= count + {4'd0, push} - {4'd0, pop};
            end
        end
    end

    // Memory request held from issue to completion; result pulse after.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.oMEM_en   <= 1'b0;
            bus.oMEM_wr   <= 1'b0;
            bus.oMEM_addr <= '0;
            bus.oMEM_dt   <= '0;
            bus.oMEM_len  <= '0;
            bus.oROB_en   <= 1'b0;
            bus.oROB_nick <= '0;
            bus.oROB_dt   <= '0;
        end else if (bus.rdy) begin
            bus.oROB_en <= 1'b0;
            if (bus.iclr) begin
                bus.oMEM_en <= 1'b0;
                bus.oMEM_wr <= 1'b0;
            end else if (issue) begin
                bus.oMEM_en   <= 1'b1;
                bus.oMEM_wr   <= h_st;
                bus.oMEM_addr <= e_s1[head] + e_imm[head];
                bus.oMEM_dt   <= h_st ? e_s2[head] : 32'd0;
                bus.oMEM_len  <= len_of(e_op[head]);
            end else if (pop) begin
                bus.oMEM_en   <= 1'b0;
                bus.oMEM_wr   <= 1'b0;
                bus.oROB_en   <= 1'b1;
                bus.oROB_nick <= e_rd[head];
                bus.oROB_dt   <= h_st ? 32'd0 : ld_fmt(e_op[head], bus.iMEM_dt);
            end
        end
    end
endmodule

// File: tb/tb_slb.sv
// Bench for slb: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_slb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slb_if bus();
    slb dut (.clk(clk), .rst(rst), .bus(bus));

    int total  = 0;
    int passed = 0;
    bit live   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h at %0t",
                      nm, act, exp, $time);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] s1, s2;
        logic [4:0]  n1, n2;
        bit          com;
    } ent_t;

    ent_t        q[$];
    bit          busy;
    logic        m_en, m_wr, r_en;
    logic [31:0] m_addr, m_dt, r_dt;
    logic [1:0]  m_len;
    logic [4:0]  r_nick;

    function automatic bit is_st(input logic [2:0] op);
        return op >= `SB;
    endfunction

    function automatic logic [1:0] lenf(input logic [2:0] op);
        if (op == `LW || op == `SW) return 2'b11;
        if (op == `LH || op == `LHU || op == `SH) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ldfmt(input logic [2:0] op,
                                          input logic [31:0] d);
        case (op)
            `LB:     return 32'($signed(d[7:0]));
            `LH:     return 32'($signed(d[15:0]));
            `LBU:    return d & 32'hFF;
            `LHU:    return d & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [36:0] grab(input logic [4:0] n,
        input logic [31:0] d, input logic pe, input logic [4:0] pn,
        input logic [31:0] pd);
        if (n != 0 && bus.iEX_en && n == bus.iEX_nick)
            return {5'd0, bus.iEX_dt};
        if (n != 0 && pe && n == pn) return {5'd0, pd};
        return {n, d};
    endfunction

    function automatic bit ready(input ent_t e);
        if (!is_st(e.op)) return e.n1 == 0;
        return e.n1 == 0 && e.n2 == 0 && e.com;
    endfunction

    task automatic model_step();
        logic        pe   = r_en;
        logic [4:0]  pn   = r_nick;
        logic [31:0] pd   = r_dt;
        bit          pop  = busy && bus.iMEM_done;
        bit          take = bus.iDP_en && q.size() < 16;
        ent_t        e;
        r_en = 0;
        if (pop) begin
            e = q[0];
            r_en = 1; r_nick = e.rd;
            r_dt = is_st(e.op) ? 32'd0 : ldfmt(e.op, bus.iMEM_dt);
            m_en = 0; m_wr = 0; busy = 0;
        end else if (!busy && q.size() > 0 && ready(q[0])) begin
            e = q[0];
            busy = 1; m_en = 1; m_wr = is_st(e.op);
            m_addr = e.s1 + e.imm; m_dt = e.s2; m_len = lenf(e.op);
        end
        foreach (q[i]) begin
            e = q[i];
            {e.n1, e.s1} = grab(e.n1, e.s1, pe, pn, pd);
            {e.n2, e.s2} = grab(e.n2, e.s2, pe, pn, pd);
            if (bus.iROB_store_en && is_st(e.op) &&
                e.rd == bus.iROB_store_nick) e.com = 1;
            q[i] = e;
        end
        if (pop) void'(q.pop_front());
        if (take) begin
            e.op = bus.iDP_op; e.imm = bus.iDP_imm; e.rd = bus.iDP_rd_nick;
            {e.n1, e.s1} = grab(bus.iDP_rs1_nick, bus.iDP_rs1_dt, pe, pn, pd);
            {e.n2, e.s2} = grab(bus.iDP_rs2_nick, bus.iDP_rs2_dt, pe, pn, pd);
            e.com = 0;
            q.push_back(e);
        end
    endtask

    // Reference model advances on every active edge.
    always @(posedge clk) begin
        live = 1;
        if (rst) begin
            q.delete(); busy = 0;
            m_en = 0; m_wr = 0; m_addr = 0; m_dt = 0; m_len = 0;
            r_en = 0; r_nick = 0; r_dt = 0;
        end else if (bus.rdy) begin
            if (bus.iclr) begin
                q.delete(); busy = 0; m_en = 0; m_wr = 0; r_en = 0;
            end else model_step();
        end
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clk) begin
        if (live) begin
            chk("full", 32'(bus.oDP_full), 32'(q.size() == 16));
            chk("mem_en", 32'(bus.oMEM_en), 32'(m_en));
            if (m_en) begin
                chk("mem_wr", 32'(bus.oMEM_wr), 32'(m_wr));
                chk("mem_addr", bus.oMEM_addr, m_addr);
                chk("mem_len", 32'(bus.oMEM_len), 32'(m_len));
                if (m_wr) chk("mem_dt", bus.oMEM_dt, m_dt);
            end
            chk("rob_en", 32'(bus.oROB_en), 32'(r_en));
            if (r_en) begin
                chk("rob_nick", 32'(bus.oROB_nick), 32'(r_nick));
                chk("rob_dt", bus.oROB_dt, r_dt);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        bus.iDP_en = 0; bus.iEX_en = 0; bus.iROB_store_en = 0;
        bus.iMEM_done = 0; bus.iclr = 0;
    endtask

    task automatic set_disp(input logic [2:0] op, input logic [31:0] imm,
        input logic [4:0] rd, input logic [31:0] s1, input logic [4:0] n1,
        input logic [31:0] s2, input logic [4:0] n2);
        bus.iDP_en = 1; bus.iDP_op = op; bus.iDP_imm = imm;
        bus.iDP_rd_nick = rd;
        bus.iDP_rs1_dt = s1; bus.iDP_rs1_nick = n1;
        bus.iDP_rs2_dt = s2; bus.iDP_rs2_nick = n2;
    endtask

    task automatic disp(input logic [2:0] op, input logic [31:0] imm,
        input logic [4:0] rd, input logic [31:0] s1, input logic [4:0] n1,
        input logic [31:0] s2, input logic [4:0] n2);
        set_disp(op, imm, rd, s1, n1, s2, n2);
        step();
    endtask

    task automatic wait_men(input string nm);
        int k = 0;
        while (!bus.oMEM_en && k < 40) begin step(); k++; end
        if (!bus.oMEM_en) begin
            total++;
            $display("FAIL %s: oMEM_en never rose within 40 cycles", nm);
        end
    endtask

    task automatic done(input logic [31:0] d);
        bus.iMEM_dt = d; bus.iMEM_done = 1;
        step();
    endtask

    task automatic commit(input logic [4:0] n);
        bus.iROB_store_en = 1; bus.iROB_store_nick = n;
        step();
    endtask

    task automatic idle_chk(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(nm, 32'(bus.oMEM_en), 32'd0);
        end
    endtask

    initial begin
        rst = 1; bus.rdy = 1; bus.iclr = 0;
        bus.iDP_en = 0; bus.iDP_op = 0; bus.iDP_imm = 0;
        bus.iDP_rd_nick = 0; bus.iDP_rs1_dt = 0; bus.iDP_rs1_nick = 0;
        bus.iDP_rs2_dt = 0; bus.iDP_rs2_nick = 0;
        bus.iEX_en = 0; bus.iEX_nick = 0; bus.iEX_dt = 0;
        bus.iROB_store_en = 0; bus.iROB_store_nick = 0;
        bus.iMEM_done = 0; bus.iMEM_dt = 0;
        step(); step();
        chk("rst_full", 32'(bus.oDP_full), 0);
        chk("rst_men", 32'(bus.oMEM_en), 0);
        chk("rst_addr", bus.oMEM_addr, 0);
        chk("rst_roben", 32'(bus.oROB_en), 0);
        rst = 0;
        step();

        disp(`LW, 32'd4, 5'd3, 32'h1000, 5'd0, 0, 5'd0);
        wait_men("lw_issue");
        chk("lw_addr", bus.oMEM_addr, 32'h1004);
        chk("lw_len", 32'(bus.oMEM_len), 32'd3);
        chk("lw_wr", 32'(bus.oMEM_wr), 0);
        done(32'hDEADBEEF);
        chk("lw_roben", 32'(bus.oROB_en), 1);
        chk("lw_nick", 32'(bus.oROB_nick), 32'd3);
        chk("lw_dt", bus.oROB_dt, 32'hDEADBEEF);
        step();
        chk("lw_pulse", 32'(bus.oROB_en), 0);

        disp(`LB, 32'd0, 5'd6, 32'hBAD, 5'd5, 0, 5'd0);
        idle_chk("lb_wait", 3);
        bus.iEX_en = 1; bus.iEX_nick = 5; bus.iEX_dt = 32'h20;
        step();
        wait_men("lb_issue");
        chk("lb_addr", bus.oMEM_addr, 32'h20);
        chk("lb_len", 32'(bus.oMEM_len), 32'd0);
        done(32'h80);
        chk("lb_dt", bus.oROB_dt, 32'hFFFFFF80);
        disp(`LBU, 32'd0, 5'd8, 32'h20, 5'd0, 0, 5'd0);
        wait_men("lbu_issue");
        done(32'h80);
        chk("lbu_dt", bus.oROB_dt, 32'h00000080);

        disp(`SW, 32'd8, 5'd7, 32'h100, 5'd0, 32'h55, 5'd0);
        idle_chk("sw_nocommit", 4);
        commit(5'd7);
        wait_men("sw_issue");
        chk("sw_wr", 32'(bus.oMEM_wr), 1);
        chk("sw_mdt", bus.oMEM_dt, 32'h55);
        chk("sw_addr", bus.oMEM_addr, 32'h108);
        done(32'h12345678);
        chk("sw_nick", 32'(bus.oROB_nick), 32'd7);
        chk("sw_dt", bus.oROB_dt, 0);

        bus.iEX_en = 1; bus.iEX_nick = 4; bus.iEX_dt = 32'h40;
        disp(`LH, 32'd2, 5'd9, 32'hBAD, 5'd4, 0, 5'd0);
        wait_men("lh_issue");
        chk("lh_addr", bus.oMEM_addr, 32'h42);
        bus.rdy = 0;
        for (int i = 0; i < 2; i++) begin
            bus.iMEM_done = 1; bus.iMEM_dt = 32'h1;
            step();
            chk("rdy_hold", 32'(bus.oMEM_en), 1);
            chk("rdy_norob", 32'(bus.oROB_en), 0);
        end
        bus.rdy = 1;
        done(32'h00008001);
        chk("lh_dt", bus.oROB_dt, 32'hFFFF8001);

        disp(`LW, 32'd0, 5'd10, 32'h200, 5'd0, 0, 5'd0);
        disp(`LHU, 32'd0, 5'd11, 32'hBAD, 5'd10, 0, 5'd0);
        wait_men("lw10_issue");
        done(32'h300);
        disp(`SH, 32'd0, 5'd12, 32'h400, 5'd0, 32'hBAD, 5'd10);
        wait_men("lhu_issue");
        chk("lhu_addr", bus.oMEM_addr, 32'h300);
        done(32'hABCD1234);
        chk("lhu_dt", bus.oROB_dt, 32'h1234);
        commit(5'd12);
        wait_men("sh_issue");
        chk("sh_mdt", bus.oMEM_dt, 32'h300);
        chk("sh_len", 32'(bus.oMEM_len), 32'd1);
        done(0);

        bus.iclr = 1; step();
        disp(`LW, 32'd0, 5'd1, 32'h10, 5'd0, 0, 5'd0);
        for (int i = 2; i <= 16; i++)
            disp(`LW, 32'd0, 5'(i), 32'h0, 5'd9, 0, 5'd0);
        chk("full16", 32'(bus.oDP_full), 1);
        disp(`LW, 32'd0, 5'd20, 32'h0, 5'd0, 0, 5'd0);
        chk("full17", 32'(bus.oDP_full), 1);
        wait_men("full_head");
        done(32'h5);
        chk("pop_full", 32'(bus.oDP_full), 0);
        chk("pop_nick", 32'(bus.oROB_nick), 32'd1);
        disp(`LW, 32'd0, 5'd21, 32'h0, 5'd9, 0, 5'd0);
        chk("refill", 32'(bus.oDP_full), 1);
        bus.iEX_en = 1; bus.iEX_nick = 9; bus.iEX_dt = 32'h80;
        step();
        wait_men("wrap_head");
        set_disp(`LW, 32'd0, 5'd22, 32'h0, 5'd0, 0, 5'd0);
        done(32'h6);
        chk("popdisp_full", 32'(bus.oDP_full), 0);
        disp(`LW, 32'd0, 5'd23, 32'h0, 5'd0, 0, 5'd0);
        chk("popdisp_refill", 32'(bus.oDP_full), 1);
        bus.iclr = 1; step();
        chk("clr_full", 32'(bus.oDP_full), 0);

        disp(`LW, 32'd0, 5'd13, 32'h50, 5'd0, 0, 5'd0);
        wait_men("clr_issue");
        bus.iclr = 1; step();
        chk("clr_men", 32'(bus.oMEM_en), 0);
        chk("clr_rob", 32'(bus.oROB_en), 0);
        done(32'h1);
        chk("clr_done_ign", 32'(bus.oROB_en), 0);
        step();
        chk("clr_idle", 32'(bus.oMEM_en), 0);

        disp(`SW, 32'd0, 5'd14, 32'h60, 5'd0, 32'h77, 5'd0);
        commit(5'd14);
        wait_men("rst_sw_issue");
        rst = 1; step();
        chk("rst2_men", 32'(bus.oMEM_en), 0);
        chk("rst2_wr", 32'(bus.oMEM_wr), 0);
        chk("rst2_dt", bus.oMEM_dt, 0);
        chk("rst2_len", 32'(bus.oMEM_len), 0);
        chk("rst2_full", 32'(bus.oDP_full), 0);
        rst = 0; step();

        disp(`SB, 32'd1, 5'd15, 32'h3, 5'd0, 32'hAB, 5'd0);
        commit(5'd15);
        wait_men("sb_issue");
        chk("sb_addr", bus.oMEM_addr, 32'h4);
        chk("sb_len", 32'(bus.oMEM_len), 0);
        done(0);
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
